cmsdk_uart_capture_mc: RTL
==========================

Name: cmsdk_uart_capture_mc

Overview:
Multi-channel simulation UART capture and command-decode block for the MCU testbench. It replaces the single-channel capture device and monitors NUM_CH UART TX lines from the MCU (for example UART0 stdout and UART1/2 loopback traffic) with parametrised bit timing and data width. Each channel reports received characters and framing errors. One designated channel also decodes escape-prefixed control commands that drive DEBUG_TESTER_ENABLE, SIMULATIONEND and AUXCTRL.

Parameters:
NUM_CH, 2, number of monitored RX lines (1..8)
BIT_CLKS, 16, CLK cycles per UART bit; even, >=4
DATA_BITS, 8, data bits per frame (5..8), LSB first, no parity, 1 stop bit
CMD_CH, 0, index of the channel whose bytes feed the command decoder
ESC_CODE, 8'h1B, command prefix byte

Ports:
CLK  input  1  capture clock (PCLK/XTAL1 domain)
RESETn  input  1  asynchronous active-low reset
RXD  input  NUM_CH  serial inputs, idle high, asynchronous to CLK
CHAR_VALID  output  NUM_CH  one-cycle pulse per good frame, per channel
CHAR_DATA  output  NUM_CH*8  channel n byte at [8n+7:8n]; bits above DATA_BITS are 0
FRAME_ERR  output  NUM_CH  one-cycle pulse when the stop bit samples low
DEBUG_TESTER_ENABLE  output  1  debug tester connect enable (level)
SIMULATIONEND  output  1  sticky end-of-simulation flag
AUXCTRL  output  8  auxiliary control byte loaded by command

Behaviour:
- Reset (RESETn low, async): all outputs 0, CHAR_DATA 0, receiver FSMs in IDLE, command FSM in C_IDLE, sync flops preset to 1.
- Each RXD bit passes through a 2-flop synchroniser. A falling edge is detected on the synchronised value.
- Per-channel receiver FSM. States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Timing reference: t0 is the first CLK edge at which sync flop 1 captures 0. The edge is detected at t0+2.
  - START: wait BIT_CLKS/2 cycles, then sample. If the line is high, treat it as a glitch and return to IDLE with no output.
  - DATA: sample bit i (i = 0..DATA_BITS-1) at t0+2+BIT_CLKS/2+(i+1)*BIT_CLKS and shift it in LSB first.
  - STOP: sample at t0+2+BIT_CLKS/2+(DATA_BITS+1)*BIT_CLKS.
    - If the sample is 1: on the next edge CHAR_VALID[n]=1 for exactly one cycle, CHAR_DATA slice updated, then IDLE.
    - If the sample is 0: FRAME_ERR[n] pulses one cycle, the data is discarded, and the FSM enters WAIT_HIGH.
  - WAIT_HIGH: return to IDLE only after a synchronised 1 is seen. A break condition therefore produces exactly one FRAME_ERR.
  - CHAR_DATA holds its value until the next good frame on that channel.
  - A new falling edge is accepted the cycle after returning to IDLE. Back-to-back frames with one stop bit must be captured without loss.
- Channels are fully independent. Simultaneous completions on several channels raise several CHAR_VALID bits in the same cycle.
- Command decoder: acts on CHAR_VALID[CMD_CH]. Every byte, command bytes included, is still reported on CHAR_VALID/CHAR_DATA.
  - C_IDLE: byte==ESC_CODE -> C_ESC; any other byte -> stay.
  - C_ESC:
    - 8'h11 -> DEBUG_TESTER_ENABLE=1, go to C_IDLE.
    - 8'h12 -> DEBUG_TESTER_ENABLE=0, go to C_IDLE.
    - 8'h04 -> SIMULATIONEND=1, go to C_IDLE.
    - 8'h13 -> C_AUX.
    - ESC_CODE -> stay in C_ESC.
    - any other byte -> C_IDLE, no effect.
  - C_AUX: next byte -> AUXCTRL=byte, go to C_IDLE.
  - Output updates occur on the same clock edge that raises CHAR_VALID[CMD_CH].
  - FRAME_ERR[CMD_CH] in any command state -> C_IDLE; a pending C_AUX is abandoned and AUXCTRL is unchanged.
- SIMULATIONEND is sticky until reset. DEBUG_TESTER_ENABLE and AUXCTRL hold until changed by command or reset.
- Reset asserted mid-frame aborts the frame immediately with no pulse.
- Reset released while RXD is low: the receiver must not start a frame until a high-to-low transition is seen.
- Fully synthesisable; no $display inside the block (printing belongs to a wrapper).

Test Plan:
- NUM_CH=2, BIT_CLKS=16: send 8'h41 on RXD[0] -> CHAR_VALID[0] high exactly at t0+155 for 1 cycle, CHAR_DATA[7:0]=8'h41, CHAR_VALID[1] stays 0.
- Send 8'h1B,8'h11 on ch0 -> DEBUG_TESTER_ENABLE=1 on the second CHAR_VALID edge. Then send 8'h1B,8'h12 -> returns to 0. Both bytes of each command appear on CHAR_VALID.
- Send 8'h1B,8'h13,8'hA5 on ch0 -> AUXCTRL=8'hA5. Send 8'h1B,8'h13, then hold ch0 low for 20 bit times -> one FRAME_ERR[0] pulse, AUXCTRL stays 8'hA5, decoder back in C_IDLE.
- Send 8'h1B,8'h04 on ch0 -> SIMULATIONEND=1 and it remains 1 after further traffic. Send 8'h1B,8'h04 on ch1 only -> no effect.
- Start frames 8'h55 on ch0 and 8'hAA on ch1 in the same cycle -> both CHAR_VALID bits pulse in the same cycle with the correct data. Back-to-back 16 frames on ch1 -> 16 pulses, no loss.
- Apply a 4-cycle low glitch on RXD[0] -> no CHAR_VALID, no FRAME_ERR. Assert RESETn low mid-frame with DATA_BITS=7 -> no pulse, outputs 0, and the next frame is received correctly with CHAR_DATA[7]=0.

Source files
------------

// File: rtl/cmsdk_uart_capture_mc.sv
// Multi-channel UART capture with per-channel framing checks and an
// escape-prefixed command decoder on one channel.
module cmsdk_uart_capture_mc #(
  parameter int          NUM_CH    = 2,
  parameter int          BIT_CLKS  = 16,
  parameter int          DATA_BITS = 8,
  parameter int          CMD_CH    = 0,
  parameter logic [7:0]  ESC_CODE  = 8'h1B
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [NUM_CH-1:0]     RXD,
  output logic [NUM_CH-1:0]     CHAR_VALID,
  output logic [NUM_CH*8-1:0]   CHAR_DATA,
  output logic [NUM_CH-1:0]     FRAME_ERR,
  output logic                  DEBUG_TESTER_ENABLE,
  output logic                  SIMULATIONEND,
  output logic [7:0]            AUXCTRL
);

  localparam int HALF = BIT_CLKS / 2;
  localparam int CW   = $clog2(BIT_CLKS);
  localparam int BW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
  typedef enum logic [1:0] {C_IDLE, C_ESC, C_AUX} cmd_state_e;

  logic [NUM_CH-1:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]           arm_q, arm_d;
  rx_state_e            state_q [NUM_CH];
  rx_state_e            state_d [NUM_CH];
  logic [CW-1:0]        cnt_q   [NUM_CH];
  logic [CW-1:0]        cnt_d   [NUM_CH];
  logic [BW-1:0]        bit_q   [NUM_CH];
  logic [BW-1:0]        bit_d   [NUM_CH];
  logic [DATA_BITS-1:0] shift_q [NUM_CH];
  logic [DATA_BITS-1:0] shift_d [NUM_CH];
  logic [NUM_CH-1:0]    valid_q, valid_d, ferr_q, ferr_d;
  logic [NUM_CH*8-1:0]  data_q, data_d;

  cmd_state_e           cmd_q, cmd_d;
  logic                 dte_q, dte_d, simend_q, simend_d;
  logic [7:0]           aux_q, aux_d;
  logic                 cmd_vld, cmd_ferr;
  logic [7:0]           cmd_byte;

  always_comb begin
    sync1_d = RXD;
    sync2_d = sync1_q;
    arm_d   = {arm_q[0], 1'b1};
    // prev stays 0 until the synchroniser holds real line samples, so a line
    // held low across reset release is not mistaken for a falling edge
    prev_d  = sync2_q & {NUM_CH{arm_q[1]}};
    valid_d = '0;
    ferr_d  = '0;
    data_d  = data_q;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch] + 1'b1;
      bit_d[ch]   = bit_q[ch];
      shift_d[ch] = shift_q[ch];
      case (state_q[ch])
        IDLE: begin
          cnt_d[ch] = '0;
          if (prev_q[ch] && !sync2_q[ch]) state_d[ch] = START;
        end
        START: begin
          if (cnt_q[ch] == CW'(HALF)) begin
            cnt_d[ch]   = '0;
            bit_d[ch]   = '0;
            state_d[ch] = sync2_q[ch] ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q[ch] == CW'(BIT_CLKS - 1)) begin
            cnt_d[ch]   = '0;
            shift_d[ch] = {sync2_q[ch], shift_q[ch][DATA_BITS-1:1]};
            bit_d[ch]   = bit_q[ch] + 1'b1;
            if (bit_q[ch] == BW'(DATA_BITS - 1)) state_d[ch] = STOP;
          end
        end
        STOP: begin
          if (cnt_q[ch] == CW'(BIT_CLKS - 1)) begin
            cnt_d[ch] = '0;
            if (sync2_q[ch]) begin
              valid_d[ch]        = 1'b1;
              data_d[ch*8 +: 8]  = 8'(shift_q[ch]);
              state_d[ch]        = IDLE;
            end else begin
              ferr_d[ch]  = 1'b1;
              state_d[ch] = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          cnt_d[ch] = '0;
          if (sync2_q[ch]) state_d[ch] = IDLE;
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  // Decoder reacts to the next-state pulse so its outputs move on the same
  // edge that raises CHAR_VALID[CMD_CH]
  assign cmd_vld  = valid_d[CMD_CH];
  assign cmd_ferr = ferr_d[CMD_CH];
  assign cmd_byte = data_d[CMD_CH*8 +: 8];

  always_comb begin
    cmd_d    = cmd_q;
    dte_d    = dte_q;
    simend_d = simend_q;
    aux_d    = aux_q;
    if (cmd_ferr) begin
      cmd_d = C_IDLE;
    end else if (cmd_vld) begin
      case (cmd_q)
        C_IDLE: if (cmd_byte == ESC_CODE) cmd_d = C_ESC;
        C_ESC: begin
          cmd_d = C_IDLE;
          if (cmd_byte == 8'h11)          dte_d    = 1'b1;
          else if (cmd_byte == 8'h12)     dte_d    = 1'b0;
          else if (cmd_byte == 8'h04)     simend_d = 1'b1;
          else if (cmd_byte == 8'h13)     cmd_d    = C_AUX;
          else if (cmd_byte == ESC_CODE)  cmd_d    = C_ESC;
        end
        C_AUX: begin
          aux_d = cmd_byte;
          cmd_d = C_IDLE;
        end
        default: cmd_d = C_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '0;
      arm_q    <= '0;
      valid_q  <= '0;
      ferr_q   <= '0;
      data_q   <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
        bit_q[ch]   <= '0;
        shift_q[ch] <= '0;
      end
      cmd_q    <= C_IDLE;
      dte_q    <= 1'b0;
      simend_q <= 1'b0;
      aux_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      arm_q    <= arm_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        bit_q[ch]   <= bit_d[ch];
        shift_q[ch] <= shift_d[ch];
      end
      cmd_q    <= cmd_d;
      dte_q    <= dte_d;
      simend_q <= simend_d;
      aux_q    <= aux_d;
    end
  end

  assign CHAR_VALID          = valid_q;
  assign CHAR_DATA           = data_q;
  assign FRAME_ERR           = ferr_q;
  assign DEBUG_TESTER_ENABLE = dte_q;
  assign SIMULATIONEND       = simend_q;
  assign AUXCTRL             = aux_q;

endmodule
